// File: rtl/prog_mem.sv
// Unified program/data memory with a reset-time byte-stream loader that releases the core once the image is in.
// Optional write protection of the low region in RUN is enabled by defining PROG_MEM_WP_EN.
module prog_mem #(
  parameter int unsigned       DEPTH      = 256,
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'('h40)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_run,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              prot_fault
);

  localparam int unsigned     IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
`ifdef PROG_MEM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  r_ld_ptr;
  logic [ADDR_W:0]   r_ld_count;
  logic              r_prot_fault;
  logic              w_ld_accept, w_ld_final, w_wp_hit, w_cpu_wr;
  logic [IDX_W-1:0]  w_cpu_idx;

  assign w_cpu_idx   = cpu_addr[IDX_W-1:0];
  assign w_ld_accept = ld_valid && (r_state != S_RUN);
  // The byte accepted while the count reads DEPTH-1 fills the last word.
  assign w_ld_final  = ld_last || (r_ld_count == LAST_CNT);
  assign w_wp_hit    = WP_EN && (r_state == S_RUN) && cpu_we && (cpu_addr < PROT_LIMIT);
  assign w_cpu_wr    = (r_state == S_RUN) && cpu_we && !w_wp_hit;

  always_comb begin
    w_state_nxt = r_state;
    cpu_run     = 1'b0;
    ld_ready    = 1'b1;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_ld_accept) w_state_nxt = w_ld_final ? S_RUN : S_LOAD;
      end
      S_RUN: begin
        cpu_run  = 1'b1;
        ld_ready = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ld_ptr     <= '0;
      r_ld_count   <= '0;
      r_prot_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_accept) begin
        r_ld_ptr   <= r_ld_ptr + 1'b1;
        r_ld_count <= r_ld_count + 1'b1;
      end
      if (w_wp_hit) r_prot_fault <= 1'b1;
    end
  end

  // Contents survive reset so a partial reload keeps earlier bytes.
  always_ff @(posedge clk) begin
    if (w_ld_accept)   r_mem[r_ld_ptr]  <= ld_data;
    else if (w_cpu_wr) r_mem[w_cpu_idx] <= cpu_wdata;
  end

  assign cpu_rdata  = r_mem[w_cpu_idx];
  assign ld_count   = r_ld_count;
  assign prot_fault = r_prot_fault;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed load/reset scenarios plus randomized CPU traffic vs a reference memory model.
module tb_prog_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ld_data;
  logic       cpu_we, cpu_run, ld_valid, ld_last, ld_ready, prot_fault;
  logic [8:0] ld_count;

  prog_mem #(.DEPTH(256), .ADDR_W(8), .DATA_W(8), .PROT_LIMIT(8'h40)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .cpu_run(cpu_run),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_count(ld_count), .prot_fault(prot_fault)
  );

  always #5 clk = ~clk;

`ifdef PROG_MEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: the image as a plain array plus loader bookkeeping.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  int         m_count;
  bit         m_run;
  bit         m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; cpu_we = 1'b0;
    tick();
    rst = 1'b0;
    m_count = 0; m_run = 1'b0; m_fault = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    if (!m_run) begin
      m_mem[m_count % 256] = d;
      m_known[m_count % 256] = 1'b1;
      m_count++;
      if (last || m_count == 256) m_run = 1'b1;
    end
  endtask

  task automatic chk_read(input string tag, input logic [7:0] a);
    cpu_addr = a;
    #1;
    if (m_known[a]) chk(tag, cpu_rdata, m_mem[a]);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"}, ld_count, m_count);
    chk({tag, ".run"},   cpu_run,  m_run);
    chk({tag, ".ready"}, ld_ready, !m_run);
    chk({tag, ".fault"}, prot_fault, m_fault);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    #1;
    if (m_known[a]) chk("wr_old", cpu_rdata, m_mem[a]);
    tick();
    cpu_we = 1'b0;
    if (m_run && WP && a < 8'h40) m_fault = 1'b1;
    else if (m_run) begin
      m_mem[a] = d; m_known[a] = 1'b1;
    end
    #1;
    if (m_known[a]) chk("wr_new", cpu_rdata, m_mem[a]);
  endtask

  logic [7:0] b [3];

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // 1: short image ending on ld_last
    do_reset();
    chk("rst.count", ld_count, 0);
    chk("rst.run", cpu_run, 0);
    chk("rst.ready", ld_ready, 1);
    chk("rst.fault", prot_fault, 0);
    send_byte(8'h01, 0); chk_status("t1.b0");
    send_byte(8'h20, 0);
    send_byte(8'h02, 0);
    send_byte(8'h21, 0); chk("t1.run_pre", cpu_run, 0);
    send_byte(8'h04, 1);
    chk("t1.count", ld_count, 5);
    chk("t1.run", cpu_run, 1);
    chk("t1.ready", ld_ready, 0);
    for (int i = 0; i < 5; i++) chk_read("t1.mem", 8'(i));
    send_byte(8'hEE, 1);           // ignored in RUN
    chk_status("t1.ignored");
    chk_read("t1.mem0", 8'h00);

    // 4: reset in the middle of a load
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      send_byte(b[i], 0);
    end
    chk_status("t4.mid");
    do_reset();
    chk_status("t4.rst");
    send_byte(8'h7E, 0);
    send_byte(8'h7F, 1);
    chk_status("t4.done");
    chk_read("t4.mem0", 8'h00);
    chk_read("t4.mem1", 8'h01);
    cpu_addr = 8'h02; #1;
    chk("t4.mem2", cpu_rdata, b[2]);

    // 5: valid toggled with garbage on the idle cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom), i == 9);
      if (i < 9) begin
        ld_data = 8'($urandom); ld_last = 1'($urandom);
        tick();
        ld_last = 1'b0;
        chk("t5.count", ld_count, m_count);
      end
    end
    chk_status("t5.done");
    for (int i = 0; i < 10; i++) chk_read("t5.mem", 8'(i));

    // 2: full image without ld_last
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("t2.run_pre", cpu_run, 0);
      send_byte(8'(i) ^ 8'hA5, 0);
    end
    chk("t2.count", ld_count, 256);
    chk("t2.run", cpu_run, 1);
    chk("t2.ready", ld_ready, 0);
    chk_read("t2.mem0", 8'h00);
    send_byte(8'h00, 0);
    chk_read("t2.mem0_kept", 8'h00);
    chk_read("t2.mem255", 8'hFF);
    chk("t2.count_sat", ld_count, 256);

    // 3: same-cycle read of a written address
    cpu_write(8'h80, 8'h3C);

    // 6: protected region
    cpu_write(8'h10, 8'h99);
    chk("t6.fault", prot_fault, m_fault);
    cpu_write(8'h40, 8'h99);
    chk("t6.fault_held", prot_fault, m_fault);

    // randomized CPU traffic in RUN, loader noise ignored
    for (int i = 0; i < 60; i++) begin
      ld_valid = 1'($urandom); ld_data = 8'($urandom);
      if ($urandom_range(0, 1) == 1) cpu_write(8'($urandom), 8'($urandom));
      else begin
        chk_read("rnd.rd", 8'($urandom));
        tick();
      end
    end
    ld_valid = 1'b0;
    chk_status("rnd.end");
    for (int i = 0; i < 256; i++) chk_read("rnd.sweep", 8'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
